// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with registered read data and full/empty flags.
//            Optional status outputs (count, sticky overflow/underflow) are
//            built in when SYNC_FIFO_STATUS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int depth = 8,
  parameter int width = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width-1:0]           din_i,
  input  logic                       wr_en_i,
  input  logic                       rd_en_i,
  output logic [width-1:0]           dout_o,
  output logic                       full_o,
`ifdef SYNC_FIFO_STATUS_EN
  output logic [$clog2(depth):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
`endif
  output logic                       empty_o
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [width-1:0] dout_q, dout_d;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Flags decode the registered pointers only; the extra MSB separates full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign w_rd_ok = rd_en_i && !empty_o;
  assign w_wr_ok = wr_en_i && (!full_o || w_rd_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    if (w_wr_ok) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (w_rd_ok) begin
      rptr_d = rptr_q + 1'b1;
      dout_d = mem_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  // Storage is deliberately not reset; reset pointers make old contents unreachable.
  always_ff @(posedge clk_i) begin
    if (w_wr_ok) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

  assign dout_o = dout_q;

`ifdef SYNC_FIFO_STATUS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (wr_en_i && !w_wr_ok);
    underflow_d = underflow_q || (rd_en_i && empty_o);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_o     = wptr_q - rptr_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Directed self-checking bench for sync_fifo (depth=8, width=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] din_i;
  logic       wr_en_i;
  logic       rd_en_i;
  logic [7:0] dout_o;
  logic       full_o;
  logic       empty_o;
`ifdef SYNC_FIFO_STATUS_EN
  logic [3:0] count_o;
  logic       overflow_o;
  logic       underflow_o;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  sync_fifo #(.depth(8), .width(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .din_i      (din_i),
    .wr_en_i    (wr_en_i),
    .rd_en_i    (rd_en_i),
    .dout_o     (dout_o),
    .full_o     (full_o),
`ifdef SYNC_FIFO_STATUS_EN
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o),
`endif
    .empty_o    (empty_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cycle(input logic wr, input logic rd, input logic [7:0] d);
    wr_en_i = wr;
    rd_en_i = rd;
    din_i   = d;
    tick();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; din_i = 8'h00;
    tick(); tick();
    reset_i = 1'b0;
    total_cnt++;
    if ({empty_o, full_o, dout_o} !== {1'b1, 1'b0, 8'h00}) $display("FAIL reset_init empty/full/dout=%b/%b/%h want 1/0/00", empty_o, full_o, dout_o); else pass_cnt++;
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b1, 1'b1, 8'h4D);
    total_cnt++;
    if (dout_o !== 8'h3C) $display("FAIL reset_pre_dout got %h want 3c", dout_o); else pass_cnt++;
    // Assert reset between edges and look before any clock edge.
    #2 reset_i = 1'b1;
    #1;
    total_cnt++;
    if ({empty_o, full_o, dout_o} !== {1'b1, 1'b0, 8'h00}) $display("FAIL reset_async empty/full/dout=%b/%b/%h want 1/0/00", empty_o, full_o, dout_o); else pass_cnt++;
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 8'hF0);
      total_cnt++;
      if (empty_o !== 1'b0) $display("FAIL fill_empty[%0d] got %b want 0", i, empty_o); else pass_cnt++;
      total_cnt++;
      if (full_o !== (i == 7)) $display("FAIL fill_full[%0d] got %b want %b", i, full_o, (i == 7)); else pass_cnt++;
    end
    cycle(1'b1, 1'b0, 8'hAA);
    total_cnt++;
    if ({full_o, empty_o} !== 2'b10) $display("FAIL fill_overwrite full/empty=%b%b want 10", full_o, empty_o); else pass_cnt++;
`ifdef SYNC_FIFO_STATUS_EN
    total_cnt++;
    if ({overflow_o, count_o} !== {1'b1, 4'd8}) $display("FAIL fill_status ovf/count=%b/%0d want 1/8", overflow_o, count_o); else pass_cnt++;
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      total_cnt++;
      if (dout_o !== 8'hF0) $display("FAIL drain_dout[%0d] got %h want f0", i, dout_o); else pass_cnt++;
      total_cnt++;
      if (full_o !== 1'b0) $display("FAIL drain_full[%0d] got %b want 0", i, full_o); else pass_cnt++;
      total_cnt++;
      if (empty_o !== (i == 7)) $display("FAIL drain_empty[%0d] got %b want %b", i, empty_o, (i == 7)); else pass_cnt++;
    end
    cycle(1'b0, 1'b1, 8'h00);
    total_cnt++;
    if ({dout_o, empty_o} !== {8'hF0, 1'b1}) $display("FAIL drain_underrun dout/empty=%h/%b want f0/1", dout_o, empty_o); else pass_cnt++;
`ifdef SYNC_FIFO_STATUS_EN
    total_cnt++;
    if ({underflow_o, count_o} !== {1'b1, 4'd0}) $display("FAIL drain_status unf/count=%b/%0d want 1/0", underflow_o, count_o); else pass_cnt++;
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    exp = 8'h01;
    // Writes 0x01..0x0C on cycles 0..11, reads from cycle 3 on, then drain three.
    for (int t = 0; t < 15; t++) begin
      cycle(t < 12, t >= 3, 8'(t + 1));
      if (t >= 3) begin
        total_cnt++;
        if (dout_o !== exp) $display("FAIL wrap_order[%0d] got %h want %h", t, dout_o, exp); else pass_cnt++;
        exp = exp + 8'h01;
      end
    end
    total_cnt++;
    if (empty_o !== 1'b1) $display("FAIL wrap_empty got %b want 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h11 + i));
    total_cnt++;
    if (full_o !== 1'b1) $display("FAIL simf_prefull got %b want 1", full_o); else pass_cnt++;
    cycle(1'b1, 1'b1, 8'h55);
    total_cnt++;
    if ({dout_o, full_o} !== {8'h11, 1'b1}) $display("FAIL simf_rw dout/full=%h/%b want 11/1", dout_o, full_o); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      total_cnt++;
      if (dout_o !== ((i == 7) ? 8'h55 : 8'(8'h12 + i))) $display("FAIL simf_drain[%0d] got %h want %h", i, dout_o, ((i == 7) ? 8'h55 : 8'(8'h12 + i))); else pass_cnt++;
    end
    total_cnt++;
    if (empty_o !== 1'b1) $display("FAIL simf_empty got %b want 1", empty_o); else pass_cnt++;
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 1'b1, 8'h66);
    total_cnt++;
    if ({dout_o, empty_o} !== {8'h55, 1'b0}) $display("FAIL sime_rw dout/empty=%h/%b want 55/0", dout_o, empty_o); else pass_cnt++;
    cycle(1'b0, 1'b1, 8'h00);
    total_cnt++;
    if ({dout_o, empty_o} !== {8'h66, 1'b1}) $display("FAIL sime_read dout/empty=%h/%b want 66/1", dout_o, empty_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h21 + i));
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b0, 8'h26);
    total_cnt++;
    if (dout_o !== 8'h21) $display("FAIL rmid_pre_dout got %h want 21", dout_o); else pass_cnt++;
`ifdef SYNC_FIFO_STATUS_EN
    total_cnt++;
    if (count_o !== 4'd5) $display("FAIL rmid_pre_count got %0d want 5", count_o); else pass_cnt++;
`endif
    #2 reset_i = 1'b1;
    #1;
    total_cnt++;
    if ({empty_o, full_o, dout_o} !== {1'b1, 1'b0, 8'h00}) $display("FAIL rmid_reset empty/full/dout=%b/%b/%h want 1/0/00", empty_o, full_o, dout_o); else pass_cnt++;
`ifdef SYNC_FIFO_STATUS_EN
    total_cnt++;
    if ({count_o, overflow_o, underflow_o} !== {4'd0, 1'b0, 1'b0}) $display("FAIL rmid_status count/ovf/unf=%0d/%b/%b want 0/0/0", count_o, overflow_o, underflow_o); else pass_cnt++;
`endif
    reset_i = 1'b0;
    tick();
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b0, 1'b1, 8'h00);
    total_cnt++;
    if ({dout_o, empty_o} !== {8'h77, 1'b1}) $display("FAIL rmid_after dout/empty=%h/%b want 77/1", dout_o, empty_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul_full();
    test_simul_empty();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterizable first-in/first-out buffer for decoupling a producer and a consumer in the same clock domain. Data words are written on `wr_en_i` and read back in the same order on `rd_en_i`. `full_o` and `empty_o` give back-pressure and underflow protection. Used as a general-purpose elastic buffer between datapath stages.

## Interface
Parameters:
- `depth`, default 8: number of storage entries; must be a power of two, ≥ 2.
- `width`, default 8: data word width in bits.

Ports:
- `clk_i`  input  1: single clock; all state updates on the rising edge.
- `reset_i`  input  1: reset, asynchronous and active-high.
- `din_i`  input  width: write data.
- `wr_en_i`  input  1: write request, sampled at the rising edge.
- `rd_en_i`  input  1: read request, sampled at the rising edge.
- `dout_o`  output  width: read data, registered.
- `full_o`  output  1: high when `depth` entries are stored.
- `empty_o`  output  1: high when 0 entries are stored.

## Operation
- Storage is a `depth` × `width` register array.
- The write pointer and read pointer are each log2(`depth`)+1 bits. The extra MSB distinguishes full from empty.
- `empty_o` = (wptr == rptr).
- `full_o` = (address bits equal) AND (MSBs differ).
- Both flags are combinational decodes of the registered pointers only, never of the inputs.

Write accept (`wr_ok`):
- `wr_en_i` AND (!`full_o` OR `rd_ok`).
- On accept, `din_i` is stored at wptr and wptr increments, wrapping modulo 2·`depth`.

Read accept (`rd_ok`):
- `rd_en_i` AND !`empty_o`.
- On accept, `dout_o` loads mem[rptr] and rptr increments.

Rejected requests and idle cycles:
- Write when full with no read in the same cycle: ignored. Memory, pointers and flags are unchanged.
- Read when empty: ignored. `dout_o` holds its value, even if a write occurs in the same cycle (no fall-through).
- `dout_o` holds its last read value whenever no read is accepted.

Simultaneous accepted read and write:
- Both pointers advance and occupancy is unchanged.
- When full, the read takes the oldest entry and the write fills the freed slot.

Other rules:
- Pointer wrap-around is transparent; ordering is preserved across any number of wraps.
- Reset (asynchronous, any time, including mid-transfer):
  - wptr = rptr = 0, so `empty_o` = 1 and `full_o` = 0.
  - `dout_o` = 0.
  - Memory contents are not cleared and are unreachable afterwards.

## Timing
- Write to visible: a word accepted at edge N can be read at edge N+1. `empty_o` falls after edge N.
- Read latency: 1 cycle. `rd_en_i` sampled high at edge N means `dout_o` is valid after edge N and is held until the next accepted read.
- Flags update only on clock edges or on asynchronous reset.
- Reset values:
  - `dout_o` = 0
  - `full_o` = 0
  - `empty_o` = 1
- Throughput: one write and one read per cycle maximum.

## Configuration
- Macro `SYNC_FIFO_STATUS_EN`.
- When defined, three extra outputs exist:
  - `count_o` (log2(`depth`)+1 bits): occupancy, computed as wptr − rptr, from 0 to `depth`.
  - `overflow_o` (1 bit): sticky; set when `wr_en_i` is high and the write is rejected.
  - `underflow_o` (1 bit): sticky; set when `rd_en_i` is high while `empty_o` is high.
- All three reset to 0. The sticky flags clear only on reset.
- When not defined, these ports and their logic are absent. The remaining behaviour is identical in both builds.

## Test plan
- Reset: assert `reset_i` asynchronously between edges → immediately `empty_o`=1, `full_o`=0, `dout_o`=0x00.
- Fill: 8 single-cycle writes of 0xF0 with `depth`=8, `width`=8 → `empty_o`=0 after the first write, `full_o`=1 after the 8th; a 9th write of 0xAA is ignored (and sets `overflow_o` with the macro).
- Drain: 8 single-cycle reads from full → `dout_o`=0xF0 one cycle after each read, `full_o`=0 after the first, `empty_o`=1 after the 8th; a 9th read leaves `dout_o`=0xF0 (and sets `underflow_o` with the macro).
- Ordering and wrap: write 0x01..0x0C interleaved with reads so the pointers wrap → read sequence is exactly 0x01..0x0C.
- Simultaneous: when full, with both requests high and `din_i`=0x55 → oldest word output, `full_o` stays 1, and 0x55 is read last. When empty, with both requests high → write stored, `dout_o` unchanged, `empty_o`=0.
- Reset mid-operation: with 5 entries stored, pulse `reset_i` → `empty_o`=1, `dout_o`=0x00 (and `count_o`=0 with the macro); the next write and read returns the new data.
